sp_sram_req_ctrl: RTL and testbench

SP_SRAM_REQ_CTRL -- requirements
Module: sp_sram_req_ctrl

---
 rtl/sp_sram_req_ctrl.sv | 108 ++++++++++
 tb/tb_sp_sram_req_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_sram_req_ctrl.sv
// sp_sram_req_ctrl: request/response front end for a single-port SRAM with 1-cycle registered read.
// Define SP_SRAM_REQ_CTRL_BURST_EN to honour req_len and enable multi-beat burst reads.
module sp_sram_req_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [LEN_WIDTH-1:0]  req_len,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_wr,
    input  logic [DATA_WIDTH-1:0] mem_qout
);
`ifdef SP_SRAM_REQ_CTRL_BURST_EN
    typedef enum logic {IDLE, BURST} state_t;
`else
    typedef enum logic {IDLE} state_t;
`endif
    state_t                         state, state_nxt;
    logic [1:0]                     cnt, occ;
    logic                           wp, rp;
    logic [1:0][DATA_WIDTH-1:0]     fifo_d;
    logic [1:0]                     fifo_l;
    logic                           in_flight, in_flight_last;
    logic                           pop, push, permit, accept, rd_issue, issue_last;
    // occ never exceeds 2, so a pop is what makes room when it is full
    assign occ       = cnt + {1'b0, in_flight};
    assign pop       = rsp_valid && rsp_ready;
    assign push      = in_flight;
    assign permit    = !occ[1] || pop;
    assign req_ready = state == IDLE && !rst && (req_wr || permit);
    assign accept    = req_valid && req_ready;
    assign mem_din   = req_wdata;
    assign mem_wr    = accept && req_wr;
    assign rsp_valid = cnt != 2'd0;
    assign rsp_data  = fifo_d[rp];
    assign rsp_last  = rsp_valid && fifo_l[rp];
`ifdef SP_SRAM_REQ_CTRL_BURST_EN
    logic [ADDR_WIDTH-1:0] baddr;
    logic [LEN_WIDTH-1:0]  rem;
    always_comb begin
        state_nxt  = state;
        mem_addr   = state == BURST ? baddr : req_addr;
        rd_issue   = state == BURST ? permit : accept && !req_wr;
        issue_last = state == BURST ? rem == LEN_WIDTH'(1) : req_len == '0;
        if (state == IDLE && rd_issue && !issue_last)
            state_nxt = BURST;
        if (state == BURST && rd_issue && issue_last)
            state_nxt = IDLE;
    end
    // rem counts beats still to issue once in BURST
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baddr <= '0;
            rem   <= '0;
        end else if (state == IDLE && rd_issue) begin
            baddr <= req_addr + 1'b1;
            rem   <= req_len;
        end else if (state == BURST && rd_issue) begin
            baddr <= baddr + 1'b1;
            rem   <= rem - 1'b1;
        end
    end
`else
    logic unused_len;
    assign unused_len = ^req_len;
    assign state_nxt  = IDLE;
    assign mem_addr   = req_addr;
    assign rd_issue   = accept && !req_wr;
    assign issue_last = 1'b1;
`endif
    // qout is sampled one edge after issue, before a following write can disturb it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 2'd0;
            wp             <= 1'b0;
            rp             <= 1'b0;
            fifo_d         <= '0;
            fifo_l         <= '0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
        end else begin
            state          <= state_nxt;
            in_flight      <= rd_issue;
            in_flight_last <= issue_last;
            if (push) begin
                fifo_d[wp] <= mem_qout;
                fifo_l[wp] <= in_flight_last;
                wp         <= !wp;
            end
            if (pop)
                rp <= !rp;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_sp_sram_req_ctrl.sv
// tb_sp_sram_req_ctrl: directed self-checking bench with a behavioural single-port SRAM.
module tb_sp_sram_req_ctrl;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_wr = 1'b0;
    logic [3:0]  req_addr = '0, req_len = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_last;
    logic [15:0] rsp_data;
    logic [3:0]  mem_addr;
    logic [15:0] mem_din, mem_qout, q;
    logic        mem_wr;
    logic [15:0] sram [0:15];
    logic [15:0] exp_b [0:7];
    logic [15:0] hold_d;
    logic        held;
    int          checks = 0, errors = 0, n;

    always #5 clk = ~clk;

    sp_sram_req_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .LEN_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_wr(mem_wr), .mem_qout(mem_qout)
    );

    always @(posedge clk) begin
        if (mem_wr) begin
            sram[mem_addr] <= mem_din;
            q <= 'x;
        end else
            q <= sram[mem_addr];
    end
    assign mem_qout = q;

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk); req_valid = 1; req_wr = 1; req_addr = a; req_wdata = d; req_len = 0;
        @(negedge clk); req_valid = 0; req_wr = 0;
    endtask

    task automatic test_reset;
        rst = 1; req_valid = 1; req_wr = 1; req_addr = 3;
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (rsp_last !== 1'b0) begin errors++; $display("FAIL reset_rsp_last got %b want 0", rsp_last); end
        checks++; if (rsp_data !== 16'h0) begin errors++; $display("FAIL reset_rsp_data got %h want 0000", rsp_data); end
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr got %b want 0", mem_wr); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
        req_valid = 0; req_wr = 0;
        @(negedge clk); rst = 0;
    endtask

    task automatic test_write_read;
        @(negedge clk); req_valid = 1; req_wr = 1; req_addr = 3; req_wdata = 16'hA5A5; req_len = 0; #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_ready got %b want 1", req_ready); end
        checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL wr_mem_wr got %b want 1", mem_wr); end
        checks++; if (mem_addr !== 4'd3) begin errors++; $display("FAIL wr_mem_addr got %h want 3", mem_addr); end
        checks++; if (mem_din !== 16'hA5A5) begin errors++; $display("FAIL wr_mem_din got %h want a5a5", mem_din); end
        @(negedge clk); req_wr = 0; #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rd_ready got %b want 1", req_ready); end
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL rd_mem_wr got %b want 0", mem_wr); end
        @(negedge clk); req_valid = 0; #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_lat1_valid got %b want 0", rsp_valid); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rd_lat2_valid got %b want 1", rsp_valid); end
        checks++; if (rsp_data !== 16'hA5A5) begin errors++; $display("FAIL rd_data got %h want a5a5", rsp_data); end
        checks++; if (rsp_last !== 1'b1) begin errors++; $display("FAIL rd_last got %b want 1", rsp_last); end
        rsp_ready = 1;
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_single_rsp got %b want 0", rsp_valid); end
        rsp_ready = 0;
    endtask

    task automatic test_write_after_read;
        @(negedge clk); req_valid = 1; req_wr = 0; req_addr = 3; req_len = 0;
        @(negedge clk); req_wr = 1; req_addr = 5; req_wdata = 16'h1234; #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL war_wr_ready got %b want 1", req_ready); end
        @(negedge clk); req_valid = 0; req_wr = 0; #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL war_valid got %b want 1", rsp_valid); end
        checks++; if (rsp_data !== 16'hA5A5) begin errors++; $display("FAIL war_data got %h want a5a5", rsp_data); end
        rsp_ready = 1;
        @(negedge clk); rsp_ready = 0; req_valid = 1; req_addr = 5; #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL war_no_wr_rsp got %b want 0", rsp_valid); end
        @(negedge clk); req_valid = 0;
        @(negedge clk); #1;
        checks++; if (rsp_data !== 16'h1234 || rsp_valid !== 1'b1) begin errors++; $display("FAIL war_rd5 got %h/%b want 1234/1", rsp_data, rsp_valid); end
        rsp_ready = 1;
        @(negedge clk); rsp_ready = 0;
    endtask

    task automatic test_stall;
        wr(7, 16'h1111); wr(8, 16'h2222); wr(9, 16'h3333);
        rsp_ready = 0;
        @(negedge clk); req_valid = 1; req_wr = 0; req_addr = 7; req_len = 0; #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL stall_rdy0 got %b want 1", req_ready); end
        @(negedge clk); req_addr = 8; #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL stall_rdy1 got %b want 1", req_ready); end
        @(negedge clk); req_addr = 9;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_full_ready got %b want 0", req_ready); end
            checks++; if (rsp_data !== 16'h1111 || rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_hold got %h/%b want 1111/1", rsp_data, rsp_valid); end
            @(negedge clk);
        end
        rsp_ready = 1; #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL stall_pop_ready got %b want 1", req_ready); end
        @(negedge clk); req_valid = 0; #1;
        checks++; if (rsp_data !== 16'h2222 || rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_b got %h/%b want 2222/1", rsp_data, rsp_valid); end
        @(negedge clk); #1;
        checks++; if (rsp_data !== 16'h3333 || rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_c got %h/%b want 3333/1", rsp_data, rsp_valid); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %b want 0", rsp_valid); end
        rsp_ready = 0;
    endtask

    task automatic preload;
        wr(14, 16'd1); wr(15, 16'd2); wr(0, 16'd3); wr(1, 16'd4);
        wr(2, 16'h102); wr(3, 16'h103); wr(4, 16'h104); wr(5, 16'h105);
    endtask

`ifdef SP_SRAM_REQ_CTRL_BURST_EN
    task automatic test_burst_wrap;
        rsp_ready = 1;
        @(negedge clk); req_valid = 1; req_wr = 0; req_addr = 14; req_len = 3; #1;
        checks++; if (mem_addr !== 4'd14) begin errors++; $display("FAIL bw_addr0 got %h want e", mem_addr); end
        @(negedge clk); req_valid = 0; #1;
        checks++; if (mem_addr !== 4'd15 || req_ready !== 1'b0) begin errors++; $display("FAIL bw_addr1 got %h/%b want f/0", mem_addr, req_ready); end
        @(negedge clk); #1;
        checks++; if (mem_addr !== 4'd0) begin errors++; $display("FAIL bw_wrap got %h want 0", mem_addr); end
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid && n < 8) begin
                checks++; if (rsp_data !== exp_b[n] || rsp_last !== (n == 3)) begin errors++; $display("FAIL bw_beat%0d got %h/%b want %h/%b", n, rsp_data, rsp_last, exp_b[n], n == 3); end
                n++;
            end
            @(negedge clk); #1;
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL bw_count got %0d want 4", n); end
        rsp_ready = 0;
    endtask

    task automatic test_back_to_back;
        rsp_ready = 1;
        @(negedge clk); req_valid = 1; req_wr = 0; req_addr = 14; req_len = 7;
        @(negedge clk); req_valid = 0;
        @(negedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_b[i] || rsp_last !== (i == 7)) begin errors++; $display("FAIL b2b_beat%0d got %b/%h/%b want 1/%h/%b", i, rsp_valid, rsp_data, rsp_last, exp_b[i], i == 7); end
            @(negedge clk); #1;
        end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want 0", rsp_valid); end
        rsp_ready = 0;
    endtask

    task automatic test_burst_stall;
        rsp_ready = 0;
        @(negedge clk); req_valid = 1; req_wr = 0; req_addr = 14; req_len = 7;
        @(negedge clk); req_valid = 0;
        n = 0; held = 0;
        for (int i = 1; i < 40; i++) begin
            rsp_ready = (i >= 6); #1;
            if (i < 6) begin
                checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bs_ready c%0d got %b want 0", i, req_ready); end
            end
            if (i == 5) begin
                checks++; if (mem_addr !== 4'd0) begin errors++; $display("FAIL bs_outstanding got %h want 0", mem_addr); end
            end
            if (rsp_valid && !rsp_ready) begin
                if (held) begin
                    checks++; if (rsp_data !== hold_d) begin errors++; $display("FAIL bs_stable got %h want %h", rsp_data, hold_d); end
                end
                hold_d = rsp_data; held = 1;
            end else
                held = 0;
            if (rsp_valid && rsp_ready && n < 8) begin
                checks++; if (rsp_data !== exp_b[n] || rsp_last !== (n == 7)) begin errors++; $display("FAIL bs_beat%0d got %h/%b want %h/%b", n, rsp_data, rsp_last, exp_b[n], n == 7); end
                n++;
            end else if (rsp_valid && rsp_ready) begin
                checks++; errors++; $display("FAIL bs_extra got %h want none", rsp_data);
            end
            @(negedge clk);
        end
        checks++; if (n !== 8) begin errors++; $display("FAIL bs_count got %0d want 8", n); end
        rsp_ready = 0;
    endtask
`else
    task automatic test_no_burst;
        rsp_ready = 1;
        @(negedge clk); req_valid = 1; req_wr = 0; req_addr = 7; req_len = 5;
        @(negedge clk); req_valid = 0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (rsp_valid) begin
                checks++; if (rsp_last !== 1'b1 || rsp_data !== 16'h1111) begin errors++; $display("FAIL nb_rsp got %h/%b want 1111/1", rsp_data, rsp_last); end
                n++;
            end
        end
        checks++; if (n !== 1) begin errors++; $display("FAIL nb_count got %0d want 1", n); end
        rsp_ready = 0;
    endtask
`endif

    task automatic test_reset_midop;
        rsp_ready = 1;
        @(negedge clk); req_valid = 1; req_wr = 0; req_addr = 14; req_len = 7;
        @(negedge clk); req_valid = 0; rst = 1; #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL rm_in_rst got %b/%b want 0/0", rsp_valid, req_ready); end
        @(negedge clk); rst = 0; req_valid = 1; req_addr = 15; req_len = 0; #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_after_valid got %b want 0", rsp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rm_after_ready got %b want 1", req_ready); end
        @(negedge clk); req_valid = 0; #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_stray got %b want 0", rsp_valid); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'd2 || rsp_last !== 1'b1) begin errors++; $display("FAIL rm_read got %b/%h/%b want 1/0002/1", rsp_valid, rsp_data, rsp_last); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_drain got %b want 0", rsp_valid); end
        rsp_ready = 0;
    endtask

    initial begin
        exp_b[0] = 16'd1; exp_b[1] = 16'd2; exp_b[2] = 16'd3; exp_b[3] = 16'd4;
        exp_b[4] = 16'h102; exp_b[5] = 16'h103; exp_b[6] = 16'h104; exp_b[7] = 16'h105;
        test_reset;
        test_write_read;
        test_write_after_read;
        test_stall;
        preload;
`ifdef SP_SRAM_REQ_CTRL_BURST_EN
        test_burst_wrap;
        test_back_to_back;
        test_burst_stall;
`else
        test_no_burst;
`endif
        test_reset_midop;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
